// File: rtl/rapid_decode_queue.sv
// Decode stage for the rapid core: RV-style instruction decode feeding a
// DEPTH-entry FIFO of decoded control bundles between fetch and execute.
module rapid_decode_queue #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic            load_upper_imm_o,
    output logic            uncond_branch_o,
    output logic            cond_branch_o,
    output logic            mem_o,
    output logic            alu_imm_o,
    output logic            alu_reg_o,
    output logic            iop_o,
    output logic            pc_load_o,
    output logic            illegal_o,
    output logic [2:0]      funct3_o,
    output logic [4:0]      rd_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [XLEN-1:0] imm_o,
    output logic [XLEN-1:0] program_counter_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic            lui;
        logic            ub;
        logic            cb;
        logic            mem;
        logic            alu_imm;
        logic            alu_reg;
        logic            iop;
        logic            pc_load;
        logic            illegal;
        logic [2:0]      funct3;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
    } bundle_t;

    bundle_t                dec;
    bundle_t                head;
    bundle_t                mem_q [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [CW-1:0]          count;
    logic                   push;
    logic                   pop;

    logic [6:0]             opcode;
    logic [2:0]             funct3;
    logic [6:0]             funct7;
    logic                   legal;
    logic [7:0]             cls;
    logic signed [31:0]     imm32;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    // cls = {lui, ub, cb, mem, alu_imm, alu_reg, iop, pc_load}
    always_comb begin
        legal = 1'b1;
        cls   = '0;
        imm32 = '0;
        case (opcode)
            7'b0110111: begin cls = 8'b1000_0010; imm32 = {instr_i[31:12], 12'b0}; end
            7'b0010111: begin cls = 8'b1000_0011; imm32 = {instr_i[31:12], 12'b0}; end
            7'b1101111: begin
                cls   = 8'b0100_0011;
                imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                         instr_i[30:21], 1'b0};
            end
            7'b1100111: begin cls = 8'b0100_0010; imm32 = {{20{instr_i[31]}}, instr_i[31:20]}; end
            7'b1100011: begin
                cls   = 8'b0010_0000;
                legal = (funct3[2:1] != 2'b01);
                imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                         instr_i[11:8], 1'b0};
            end
            7'b0000011: begin
                cls   = 8'b0001_0010;
                legal = (funct3 != 3'b111);
                imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            7'b0100011: begin
                cls   = 8'b0001_0000;
                legal = !funct3[2];
                imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            7'b0010011: begin cls = 8'b0000_1010; imm32 = {{20{instr_i[31]}}, instr_i[31:20]}; end
            7'b0110011: begin
                cls   = 8'b0000_0110;
                legal = (funct7 == 7'b0000000) ||
                        ((funct7 == 7'b0100000) && (funct3 == 3'b000 || funct3 == 3'b101));
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        dec         = '0;
        dec.funct3  = funct3;
        dec.rd      = instr_i[11:7];
        dec.rs1     = instr_i[19:15];
        dec.rs2     = instr_i[24:20];
        dec.pc      = pc_i;
        dec.illegal = !legal;
        {dec.lui, dec.ub, dec.cb, dec.mem, dec.alu_imm, dec.alu_reg, dec.iop, dec.pc_load}
            = legal ? cls : '0;
        dec.imm     = legal ? XLEN'(imm32) : '0;
    end

    assign in_ready_o  = (count != CW'(DEPTH));
    assign out_valid_o = (count != '0);
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr] <= dec;
                wr_ptr        <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    assign head = out_valid_o ? mem_q[rd_ptr] : '0;

    assign load_upper_imm_o  = head.lui;
    assign uncond_branch_o   = head.ub;
    assign cond_branch_o     = head.cb;
    assign mem_o             = head.mem;
    assign alu_imm_o         = head.alu_imm;
    assign alu_reg_o         = head.alu_reg;
    assign iop_o             = head.iop;
    assign pc_load_o         = head.pc_load;
    assign illegal_o         = head.illegal;
    assign funct3_o          = head.funct3;
    assign rd_o              = head.rd;
    assign rs1_o             = head.rs1;
    assign rs2_o             = head.rs2;
    assign imm_o             = head.imm;
    assign program_counter_o = head.pc;

endmodule

// File: doc/rapid_decode_queue.md
# rapid_decode_queue

Parametrised decode stage for the rapid core. Accepts fetched 32-bit RV-style instructions with their PC over a valid/ready handshake, and decodes each one into the core's control bundle (class flags, funct3, immediate, PC, operand-select). The decoded bundles are buffered in a DEPTH-entry FIFO between fetch and execute. Adds backpressure, flush, illegal-instruction detection and XLEN generalisation.

## Interface
- XLEN, 32, datapath width of imm_o/pc (32 or 64)
- DEPTH, 2, decoded-bundle FIFO entries (power of two, >= 2)
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous discard of all buffered entries
- in_valid_i  in  1  instruction valid
- in_ready_o  out  1  queue can accept
- instr_i  in  32  instruction word
- pc_i  in  XLEN  instruction address
- out_valid_o  out  1  head bundle valid
- out_ready_i  in  1  execute consumes head
- load_upper_imm_o, uncond_branch_o, cond_branch_o, mem_o, alu_imm_o, alu_reg_o, iop_o, pc_load_o, illegal_o  out  1 each  control flags
- funct3_o  out  3  instr[14:12]
- rd_o, rs1_o, rs2_o  out  5 each  register indices
- imm_o  out  XLEN  sign-extended immediate
- program_counter_o  out  XLEN  PC of head instruction

## Operation
- Decode on instr[6:0] (instr[1:0] != 11 -> illegal):
  - LUI 0110111: load_upper_imm, iop.
  - AUIPC 0010111: load_upper_imm, pc_load, iop.
  - JAL 1101111: uncond_branch, pc_load, iop.
  - JALR 1100111: uncond_branch, iop.
  - BRANCH 1100011: cond_branch.
  - LOAD 0000011: mem, iop.
  - STORE 0100011: mem.
  - OP-IMM 0010011: alu_imm, iop.
  - OP 0110011: alu_reg, iop.
- iop = instruction writes rd; pc_load = ALU operand A is PC.
- Immediates: I/S/B/U/J per format, sign-extended from instr[31] to XLEN. U = instr[31:12]<<12. R-type imm = 0.
- Illegal cases:
  - any other opcode;
  - BRANCH funct3 010/011;
  - LOAD funct3 111;
  - STORE funct3[2]=1;
  - OP funct7 other than 0000000, or 0100000 with funct3 not 000/101.
- Illegal instructions are still enqueued: all class flags, iop and pc_load = 0, imm 0, illegal_o = 1. funct3/rd/rs1/rs2/PC are passed through.
- Decode is combinational on the input; the decoded bundle is written into the FIFO on push (in_valid_i & in_ready_o).
- FIFO:
  - wr/rd pointers of log2(DEPTH) bits, wrapping modulo DEPTH; count of log2(DEPTH)+1 bits.
  - in_ready_o = (count != DEPTH), registered state only, no dependence on out_ready_i.
  - out_valid_o = (count != 0).
  - Pop = out_valid_o & out_ready_i.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
- All bundle outputs are forced to 0 whenever out_valid_o = 0.
- Flush:
  - clears pointers and count on that edge; any push or pop in the flush cycle is discarded.
  - flush has priority over push/pop.

## Timing
- Reset (async assert, any cycle, including mid-transfer): count/pointers 0, storage cleared, out_valid_o 0, in_ready_o 1, all bundle outputs 0.
- Latency: push at edge N into an empty FIFO -> out_valid_o and the bundle are visible in cycle N+1.
- Throughput: 1 instruction/cycle sustained while out_ready_i = 1.
- Full (count = DEPTH): in_ready_o 0. A pop at edge N raises in_ready_o in cycle N+1; there is no same-cycle pass-through.
- Empty: out_valid_o 0. Data never bypasses the FIFO.
- Flush at edge N: cycle N+1 has out_valid_o 0 and in_ready_o 1.
- Source must hold instr_i/pc_i/in_valid_i stable until accepted. Execute may deassert out_ready_i at any time.

## Test plan
- Reset: hold rst_ni low with in_valid_i = 1 -> out_valid_o 0, in_ready_o 1, all outputs 0. Release -> first push accepted on the first edge.
- LUI: 0x123452B7, pc 0x100 -> next cycle out_valid_o 1, load_upper_imm 1, iop 1, rd 5, imm 0x12345000, program_counter 0x100, illegal 0.
- BEQ: 0xFE208EE3 (beq x1,x2,-4), pc 0x200 -> cond_branch 1, funct3 000, rs1 1, rs2 2, imm 0xFFFFFFFC, iop 0. With XLEN=64: imm 0xFFFFFFFFFFFFFFFC.
- Backpressure/wrap, DEPTH=2:
  - hold out_ready_i 0 and offer A, B, C -> in_ready_o 0 after B; C stalls.
  - raise out_ready_i -> outputs A, B, C in order across pointer wrap.
  - 10 back-to-back pushes with out_ready_i = 1 -> no bubbles.
- Flush: FIFO full plus in_valid_i 1 and flush_i 1 on the same edge -> next cycle out_valid_o 0, in_ready_o 1; the offered instruction is never output.
- Illegal: 0x00000000 and 0x4000E033 (OP funct7 0100000, funct3 110) -> illegal_o 1, all class flags and iop 0, imm 0.
